// File: rtl/instruction_loader_if.sv
// Byte-in / word-write bus between the debug UART side and the instruction loader.
// With LOADER_TIMEOUT_EN defined the bus also carries the inter-byte timeout flag.
interface instruction_loader_if #(
    parameter int unsigned NB      = 32,
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned CW      = 9
);
    logic               start;
    logic [NB_DATA-1:0] rx_data;
    logic               rx_valid;
    logic               instruction_write;
    logic [NB-1:0]      instruction;
    logic [NB-1:0]      address_memory_ins;
    logic [CW-1:0]      word_count;
    logic               busy;
    logic               done;
    logic               overflow;
`ifdef LOADER_TIMEOUT_EN
    logic               timeout;

    modport master (
        output start, rx_data, rx_valid,
        input  instruction_write, instruction, address_memory_ins, word_count,
        input  busy, done, overflow, timeout
    );
    modport slave (
        input  start, rx_data, rx_valid,
        output instruction_write, instruction, address_memory_ins, word_count,
        output busy, done, overflow, timeout
    );
`else
    modport master (
        output start, rx_data, rx_valid,
        input  instruction_write, instruction, address_memory_ins, word_count,
        input  busy, done, overflow
    );
    modport slave (
        input  start, rx_data, rx_valid,
        output instruction_write, instruction, address_memory_ins, word_count,
        output busy, done, overflow
    );
`endif
endinterface

// File: rtl/instruction_loader.sv
// Assembles big-endian UART bytes into instructions and writes them to instruction memory.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module instruction_loader #(
    parameter int unsigned   NB        = 32,
    parameter int unsigned   NB_DATA   = 8,
    parameter int unsigned   TAM_I     = 256,
    parameter logic [NB-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int unsigned   TIMEOUT   = 1000000
) (
    input logic               i_clk,
    input logic               i_reset,
    instruction_loader_if.slave bus
);
    localparam int unsigned CW = $clog2(TAM_I) + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e        state_q;
    logic [1:0]    byte_idx_q;
    logic [NB-1:0] asm_q;
    logic          pending_q;   // full word assembled, write goes out next edge
    logic          write_q;
    logic [NB-1:0] instr_q;
    logic [NB-1:0] addr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt_q;
    logic          timeout_q;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= StIdle;
            byte_idx_q <= 2'd0;
            asm_q      <= '0;
            pending_q  <= 1'b0;
            write_q    <= 1'b0;
            instr_q    <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            write_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_q    <= StLoad;
                        byte_idx_q <= 2'd0;
                        pending_q  <= 1'b0;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
                        cnt_q      <= '0;
                        timeout_q  <= 1'b0;
`endif
                    end
                end
                StLoad: begin
                    pending_q <= bus.rx_valid && (byte_idx_q == 2'd3);
                    if (bus.rx_valid) begin
                        asm_q[NB - NB_DATA * (int'(byte_idx_q) + 1) +: NB_DATA] <= bus.rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_TIMEOUT_EN
                        cnt_q      <= '0;
                    end else if (byte_idx_q != 2'd0) begin
                        if (cnt_q == TW'(TIMEOUT - 1)) begin
                            state_q    <= StDone;
                            timeout_q  <= 1'b1;
                            byte_idx_q <= 2'd0;
                        end else begin
                            cnt_q <= cnt_q + TW'(1);
                        end
`endif
                    end
                    // Separate assembly register lets the next word start during this write.
                    if (pending_q) begin
                        write_q <= 1'b1;
                        instr_q <= asm_q;
                        addr_q  <= NB'({count_q, 2'b00});
                        count_q <= count_q + CW'(1);
                        if (asm_q == HALT_WORD) begin
                            state_q    <= StDone;
                            byte_idx_q <= 2'd0;
                        end else if (count_q == CW'(TAM_I - 1)) begin
                            state_q    <= StDone;
                            overflow_q <= 1'b1;
                            byte_idx_q <= 2'd0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.instruction_write  = write_q;
    assign bus.instruction        = instr_q;
    assign bus.address_memory_ins = addr_q;
    assign bus.word_count         = count_q;
    assign bus.busy               = (state_q == StLoad);
    assign bus.done               = (state_q == StDone);
    assign bus.overflow           = overflow_q;
`ifdef LOADER_TIMEOUT_EN
    assign bus.timeout            = timeout_q;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader built with TAM_I=4 and TIMEOUT=16.
// Writes are logged on the falling edge and checked against hand-computed values.
module tb_instruction_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_edge = 0;
    int   first_wr_cycle = 0;

    logic [31:0] wr_data [16];
    logic [31:0] wr_addr [16];
    int          wr_cycle [16];
    int          wr_n = 0;

    instruction_loader_if #(.NB(32), .NB_DATA(8), .CW(3)) bus ();

    instruction_loader #(
        .NB(32), .NB_DATA(8), .TAM_I(4), .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT(16)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.instruction_write === 1'b1 && wr_n < 16) begin
            wr_data[wr_n]  = bus.instruction;
            wr_addr[wr_n]  = bus.address_memory_ins;
            wr_cycle[wr_n] = cyc;
            wr_n++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        last_edge = cyc;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs",
              {bus.instruction_write, bus.busy, bus.done, bus.overflow, bus.word_count,
               bus.instruction, bus.address_memory_ins}, '0);
        #20 rst_n = 1'b1;
        idle_cycles(2);
        check("idle_not_busy", {bus.busy, bus.done}, 2'b00);

        // Basic program plus HALT, bytes back-to-back.
        pulse_start();
        check("busy_after_start", bus.busy, 1'b1);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        first_wr_cycle = last_edge + 1;
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        idle_cycles(3);
        check("t1_write_count", wr_n, 2);
        check("t1_word0", wr_data[0], 32'h2008_0005);
        check("t1_addr0", wr_addr[0], 32'h0);
        check("t1_word1", wr_data[1], 32'hFFFF_FFFF);
        check("t1_addr1", wr_addr[1], 32'h4);
        check("t2_latency", wr_cycle[0], first_wr_cycle);
        check("t2_spacing", wr_cycle[1] - wr_cycle[0], 4);
        check("t1_done", {bus.done, bus.busy, bus.overflow}, 3'b100);
        check("t1_word_count", bus.word_count, 3'd2);

        // Bytes in DONE are dropped.
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        idle_cycles(2);
        check("t5_done_drop", wr_n, 2);
        check("t5_done_count", bus.word_count, 3'd2);

        // New load; a start pulse mid-load must be ignored.
        pulse_start();
        check("t5_count_cleared", bus.word_count, 3'd0);
        send_byte(8'h11); send_byte(8'h22);
        bus.start = 1'b1;
        send_byte(8'h33);
        bus.start = 1'b0;
        send_byte(8'h44);
        idle_cycles(2);
        check("t5_word", wr_data[2], 32'h1122_3344);
        check("t5_addr_restart", wr_addr[2], 32'h0);
        check("t5_start_ignored", {bus.busy, bus.word_count}, {1'b1, 3'd1});

        // Overflow: words 2..4 fill memory, the fifth non-HALT word is dropped.
        for (int w = 1; w <= 4; w++) begin
            for (int k = 0; k < 4; k++) send_byte(8'(w));
        end
        idle_cycles(3);
        check("t3_write_count", wr_n, 6);
        check("t3_addr1", wr_addr[3], 32'h4);
        check("t3_addr3", wr_addr[5], 32'hC);
        check("t3_last_word", wr_data[5], 32'h0303_0303);
        check("t3_flags", {bus.overflow, bus.done, bus.busy}, 3'b110);
        check("t3_word_count", bus.word_count, 3'd4);

        // Reset mid-word.
        pulse_start();
        check("t4_start_clears", {bus.overflow, bus.done, bus.busy, bus.word_count},
              {3'b001, 3'd0});
        send_byte(8'hAB); send_byte(8'hCD);
        #3 rst_n = 1'b0;
        #1;
        check("t4_async_reset",
              {bus.instruction_write, bus.busy, bus.done, bus.overflow, bus.word_count,
               bus.instruction, bus.address_memory_ins}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(2);
        check("t4_no_write", wr_n, 6);
        pulse_start();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        idle_cycles(2);
        check("t4_reload_count", wr_n, 7);
        check("t4_reload_addr", wr_addr[6], 32'h0);
        check("t4_reload_word", wr_data[6], 32'h0102_0304);

        // Stalled partial word.
        send_byte(8'h55); send_byte(8'h55); send_byte(8'h55);
`ifdef LOADER_TIMEOUT_EN
        idle_cycles(15);
        check("t6_before_timeout", {bus.busy, bus.done, bus.timeout}, 3'b100);
        idle_cycles(1);
        check("t6_timeout", {bus.busy, bus.done, bus.timeout}, 3'b011);
        check("t6_no_write", wr_n, 7);
`else
        idle_cycles(1000);
        check("t6_still_busy", {bus.busy, bus.done}, 2'b10);
        check("t6_no_write", wr_n, 7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
